// File: rtl/fifo_tb_pkg.sv
// Shared types and defaults for the FIFO bench reader/writer blocks.
package fifo_tb_pkg;
  typedef enum logic [2:0] {IDLE, POP, WAIT, DRAIN, DONE} rd_state_e;
  localparam int DEF_BITS    = 32;
  localparam int DEF_COUNT_W = 32;
endpackage

// File: rtl/fifo_read_scoreboard.sv
// Compares each popped word (valid the cycle after the pop) to an incrementing expected value.
module fifo_read_scoreboard #(
  parameter int BITS  = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pop,
  input  logic [BITS-1:0]  start_value,
  input  logic [BITS-1:0]  rdata,
  output logic             mismatch,
  output logic [ERR_W-1:0] error_count
);
  logic            chk_v;
  logic [BITS-1:0] exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_v       <= 1'b0;
      exp_q       <= '0;
      mismatch    <= 1'b0;
      error_count <= '0;
    end else begin
      chk_v    <= pop;
      mismatch <= 1'b0;
      if (clr) begin
        exp_q       <= start_value;
        error_count <= '0;
      end else if (chk_v) begin
        // expected value advances on every compare so one bad word costs one error
        exp_q <= exp_q + 1'b1;
        if (rdata != exp_q) begin
          mismatch <= 1'b1;
          if (error_count != '1) error_count <= error_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fifo_read_checker.sv
// Read-side FIFO sink: paced pops, in-order pattern check, stall timeout.
module fifo_read_checker import fifo_tb_pkg::*; #(
  parameter int BITS    = DEF_BITS,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int PACE_W  = 4,
  parameter int TIMEOUT = 1024,
  parameter int ERR_W   = 16
) (
  input  logic               read_clk,
  input  logic               read_rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_words,
  input  logic [BITS-1:0]    start_value,
  input  logic [PACE_W-1:0]  pace,
  input  logic               p_read_empty,
  input  logic [BITS-1:0]    p_read_data,
  output logic               p_read_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               mismatch,
  output logic [ERR_W-1:0]   error_count,
  output logic [COUNT_W-1:0] words_read
);
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  rd_state_e          state;
  logic [COUNT_W-1:0] num_q;
  logic [PACE_W-1:0]  pace_q, pace_cnt;
  logic [STALL_W-1:0] stall;
  logic               pop, clr;

  // reset gates the pop so nothing is requested during the reset cycle
  assign pop       = (state == POP) && !p_read_empty && !read_rst;
  assign p_read_en = pop;
  assign clr       = (state == IDLE) && start;

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      state      <= IDLE;
      num_q      <= '0;
      pace_q     <= '0;
      pace_cnt   <= '0;
      stall      <= '0;
      words_read <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          num_q      <= num_words;
          pace_q     <= pace;
          stall      <= '0;
          words_read <= '0;
          timeout    <= 1'b0;
          if (num_words == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= POP;
            busy  <= 1'b1;
          end
        end
        POP: if (pop) begin
          words_read <= words_read + 1'b1;
          stall      <= '0;
          if (words_read + 1'b1 == num_q) state <= DRAIN;
          else if (pace_q != '0) begin
            state    <= WAIT;
            pace_cnt <= pace_q - 1'b1;
          end
        end else if (stall == STALL_W'(TIMEOUT - 1)) begin
          timeout <= 1'b1;
          state   <= DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end else begin
          stall <= stall + 1'b1;
        end
        WAIT: if (pace_cnt == '0) state <= POP;
              else pace_cnt <= pace_cnt - 1'b1;
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fifo_read_scoreboard #(.BITS(BITS), .ERR_W(ERR_W)) u_sb (
    .clk         (read_clk),
    .rst         (read_rst),
    .clr         (clr),
    .pop         (pop),
    .start_value (start_value),
    .rdata       (p_read_data),
    .mismatch    (mismatch),
    .error_count (error_count)
  );
endmodule

// File: tb/tb_fifo_read_checker.sv
// Scoreboard bench for fifo_read_checker with a queue-based FIFO model.
module tb_fifo_read_checker;
  localparam int BITS = 32, COUNT_W = 16, PACE_W = 4, TIMEOUT = 8, ERR_W = 5;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic               read_clk = 1'b0, read_rst = 1'b1, start = 1'b0;
  logic [COUNT_W-1:0] num_words = '0;
  logic [BITS-1:0]    start_value = '0, p_read_data = '0;
  logic [PACE_W-1:0]  pace = '0;
  logic               p_read_empty = 1'b1;
  logic               p_read_en, busy, done, timeout, mismatch;
  logic [ERR_W-1:0]   error_count;
  logic [COUNT_W-1:0] words_read;

  typedef struct { int words; int errs; bit tmo; } res_t;

  logic [BITS-1:0] fifo_q[$];
  bit              flag_q[$];
  res_t            res_q[$];
  int              pop_cyc[$];
  int              errors = 0, checks = 0, cyc = 0, hold_run = 0;
  bit              rand_hold = 1'b0, s0 = 1'b0, s1 = 1'b0;

  always #5 read_clk = ~read_clk;

  fifo_read_checker #(.BITS(BITS), .COUNT_W(COUNT_W), .PACE_W(PACE_W),
                      .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .read_clk(read_clk), .read_rst(read_rst), .start(start), .num_words(num_words),
    .start_value(start_value), .pace(pace), .p_read_empty(p_read_empty),
    .p_read_data(p_read_data), .p_read_en(p_read_en), .busy(busy), .done(done),
    .timeout(timeout), .mismatch(mismatch), .error_count(error_count), .words_read(words_read)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // FIFO model: data registered on pop, empty flag updated with the clock
  always @(posedge read_clk) begin
    cyc <= cyc + 1;
    if (p_read_en && fifo_q.size() > 0) p_read_data <= fifo_q.pop_front();
    if (rand_hold && hold_run < 3 && $urandom_range(3) == 0) begin
      hold_run++;
      p_read_empty <= 1'b1;
    end else begin
      hold_run = 0;
      p_read_empty <= (fifo_q.size() == 0);
    end
  end

  // monitor: per-pop mismatch expectation two cycles later, run result on done
  always @(negedge read_clk) begin
    res_t r;
    if (read_rst) begin
      s0 = 1'b0; s1 = 1'b0;
      flag_q.delete();
      res_q.delete();
    end else begin
      chk("pop_gate", {63'd0, p_read_en & p_read_empty}, 64'd0);
      chk("mismatch", {63'd0, mismatch}, {63'd0, s0});
      s0 = s1;
      s1 = 1'b0;
      if (p_read_en) begin
        pop_cyc.push_back(cyc);
        if (flag_q.size() == 0) fail("unexpected_pop");
        else s1 = flag_q.pop_front();
      end
      if (done) begin
        if (res_q.size() == 0) fail("unexpected_done");
        else begin
          r = res_q.pop_front();
          chk("words_read", 64'(words_read), 64'(r.words));
          chk("error_count", 64'(error_count), 64'(r.errs));
          chk("timeout", {63'd0, timeout}, {63'd0, r.tmo});
          chk("busy_at_done", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  // poke: 1 = extra start mid-run, 2 = start during the done cycle (both must be ignored)
  task automatic run(input int n, input logic [BITS-1:0] sv, input logic [BITS-1:0] dbase,
                     input int pc, input int avail, input int bad_pct, input int poke,
                     output int s_cyc, output int d_cyc);
    res_t r;
    int e = 0;
    logic [BITS-1:0] w;
    bit got = 1'b0;
    for (int i = 0; i < avail; i++) begin
      w = dbase + BITS'(i);
      if ($urandom_range(99) < bad_pct) w = w ^ (BITS'(1) << $urandom_range(BITS-1));
      fifo_q.push_back(w);
      flag_q.push_back(w != sv + BITS'(i));
      if (w != sv + BITS'(i)) e++;
    end
    r.words = avail;
    r.errs  = (e > ERR_MAX) ? ERR_MAX : e;
    r.tmo   = (avail < n);
    res_q.push_back(r);
    repeat (2) @(negedge read_clk);
    pop_cyc.delete();
    start = 1'b1; num_words = COUNT_W'(n); start_value = sv; pace = PACE_W'(pc);
    @(negedge read_clk);
    start = 1'b0;
    s_cyc = cyc - 1;
    d_cyc = -1;
    if (n != 0) chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int k = 0; k < 2000; k++) begin
      if (done) begin got = 1'b1; d_cyc = cyc; break; end
      if (poke == 1 && k == 1) begin start = 1'b1; num_words = 99; end
      else start = 1'b0;
      @(negedge read_clk);
    end
    start = 1'b0;
    if (!got) fail("done_wait_expired");
    if (poke == 2) begin start = 1'b1; num_words = 5; end
    @(negedge read_clk);
    start = 1'b0;
    chk("done_pulse_width", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    if (poke == 2) begin
      @(negedge read_clk);
      chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    int s, d, n, a;
    logic [BITS-1:0] v;
    fifo_q.push_back(32'h1234);
    repeat (3) @(negedge read_clk);
    chk("rst_p_read_en", {63'd0, p_read_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_timeout", {63'd0, timeout}, 64'd0);
    chk("rst_mismatch", {63'd0, mismatch}, 64'd0);
    chk("rst_error_count", 64'(error_count), 64'd0);
    chk("rst_words_read", 64'(words_read), 64'd0);
    fifo_q.delete();
    read_rst = 1'b0;
    repeat (2) @(negedge read_clk);

    run(16, 0, 0, 0, 16, 0, 2, s, d);
    chk("t1_done_latency", 64'(d - s), 64'd18);
    chk("t1_pops", 64'(pop_cyc.size()), 64'd16);
    for (int i = 0; i < pop_cyc.size(); i++) chk("t1_pop_cycle", 64'(pop_cyc[i] - s), 64'(i + 1));

    run(16, 1, 0, 0, 16, 0, 0, s, d);

    run(4, 32'h55, 32'h55, 3, 4, 0, 1, s, d);
    chk("t3_pops", 64'(pop_cyc.size()), 64'd4);
    for (int i = 0; i < pop_cyc.size(); i++) chk("t3_pop_cycle", 64'(pop_cyc[i] - s), 64'(1 + 4 * i));

    run(8, 0, 0, 0, 0, 0, 0, s, d);
    chk("t4_no_pops", 64'(pop_cyc.size()), 64'd0);
    chk("t4_done_latency", 64'(d - s), 64'd9);

    run(4, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 4, 0, 0, s, d);
    run(40, 1000, 0, 1, 40, 0, 0, s, d);
    run(0, 7, 7, 0, 0, 0, 0, s, d);
    chk("zero_done_latency", 64'(d - s), 64'd1);

    // reset in the middle of a run
    for (int i = 0; i < 16; i++) begin
      fifo_q.push_back(BITS'(i));
      flag_q.push_back(1'b0);
    end
    res_q.push_back('{16, 0, 1'b0});
    repeat (2) @(negedge read_clk);
    pop_cyc.delete();
    start = 1'b1; num_words = 16; start_value = 0; pace = 0;
    @(negedge read_clk);
    start = 1'b0;
    for (int k = 0; k < 100 && pop_cyc.size() < 5; k++) begin
      @(negedge read_clk);
      #1;
    end
    if (pop_cyc.size() < 5) fail("t6_pop_wait_expired");
    @(posedge read_clk);
    #1 read_rst = 1'b1;
    @(negedge read_clk);
    chk("t6_p_read_en", {63'd0, p_read_en}, 64'd0);
    @(posedge read_clk);
    #1 read_rst = 1'b0;
    fifo_q.delete();
    @(negedge read_clk);
    chk("t6_pops", 64'(pop_cyc.size()), 64'd5);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_words_read", 64'(words_read), 64'd0);
    chk("t6_error_count", 64'(error_count), 64'd0);
    chk("t6_timeout", {63'd0, timeout}, 64'd0);
    a = 0;
    repeat (6) begin
      if (done) a++;
      @(negedge read_clk);
    end
    chk("t6_no_done", 64'(a), 64'd0);
    run(8, 32'hA0, 32'hA0, 0, 8, 0, 0, s, d);

    rand_hold = 1'b1;
    repeat (25) begin
      n = $urandom_range(24, 1);
      a = ($urandom_range(4) == 0) ? $urandom_range(n - 1, 0) : n;
      v = $urandom;
      run(n, v, v, $urandom_range(3), a, 20, 0, s, d);
      chk("rand_pops", 64'(pop_cyc.size()), 64'(a));
    end
    rand_hold = 1'b0;
    repeat (4) @(negedge read_clk);
    chk("leftover_results", 64'(res_q.size()), 64'd0);
    chk("leftover_flags", 64'(flag_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
